ex_muldiv: RTL and testbench
============================

# ex_muldiv

Parametrised multi-cycle execute unit for the RV32M multiply and divide instructions. It sits beside the single-cycle ALU in the EX stage and takes the same decoded operands and `aluop` code. While it works it raises a stall request to `ctrl`, then returns one result for the `ex_mem` write-back path. The state machine is iterative, one result bit per cycle, with abort-on-flush. The width is generic.

## Interface
Parameters:
- `XLEN`, 32: operand and result width. Must be at least 8 and a power of two.
- `CNT_W`, `$clog2(XLEN)+1`: iteration counter width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-low (`RstEnable` = 1'b0).
- `start_i` in 1: launch an operation. Sampled only in IDLE.
- `aluop_i` in `AluOpBus`: one of `EXE_MUL`, `EXE_MULH`, `EXE_MULHSU`, `EXE_MULHU`, `EXE_DIV`, `EXE_DIVU`, `EXE_REM`, `EXE_REMU`.
- `reg1_i` in XLEN: rs1, the multiplicand or dividend.
- `reg2_i` in XLEN: rs2, the multiplier or divisor.
- `wd_i` in `RegAddrBus`: destination register.
- `flush_i` in 1: abort the operation in flight (branch or trap).
- `stall_req_o` out 1: request to hold the pipeline.
- `done_o` out 1: one-cycle pulse; `result_o` and `wd_o` are valid in that cycle.
- `result_o` out XLEN: the result.
- `wd_o` out `RegAddrBus`: latched destination register.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - `start_i` with a legal `aluop_i` latches op, operands and `wd_i`, then moves to CALC with cnt = 0.
  - An illegal op is ignored.
- CALC, multiply (shift-add, 2·XLEN accumulator):
  - Operands are sign-extended per op to XLEN+1 bits.
  - The product is accumulated signed.
  - Exactly XLEN iterations, then FIX.
- CALC, divide (restoring, unsigned magnitudes):
  - Signed ops take |a| and |b| first.
  - One quotient bit per cycle; XLEN iterations, then FIX.
- FIX:
  - Applies the sign correction: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - Selects low (`MUL`) or high (`MULH*`) product word, or quotient or remainder.
  - Writes `result_o`, then moves to DONE.
- DONE: `done_o` = 1 for one cycle, then IDLE. `result_o` and `wd_o` hold until the next FIX.
- Divisor = 0: CALC is skipped, IDLE goes to FIX directly.
  - `DIV`/`DIVU` return all-ones.
  - `REM`/`REMU` return the dividend.
- Signed overflow (`DIV`/`REM` with dividend = −2^(XLEN−1), divisor = −1): CALC is skipped.
  - `DIV` returns the dividend.
  - `REM` returns 0.
- `stall_req_o` is combinational.
  - It is 1 when (IDLE and `start_i` with a legal op), or in CALC or FIX.
  - It is 0 in DONE, so the pipeline advances in the same cycle `done_o` is high.
- `flush_i`:
  - In any state other than IDLE it returns the unit to IDLE next cycle with no `done_o`; `result_o` is unchanged.
  - `flush_i` together with `start_i` in IDLE: the flush wins and nothing is launched.
- `start_i` outside IDLE is ignored.
- Arithmetic:
  - Counter wrap is never used; the compare is cnt == XLEN−1.
  - All negation is two's complement modulo 2^XLEN.

## Timing
- Reset values: state IDLE, `stall_req_o` 0, `done_o` 0, `result_o` 0, `wd_o` 0, counter and accumulators 0.
- Normal latency: start in cycle 0; CALC in cycles 1..XLEN; FIX in cycle XLEN+1; `done_o` in cycle XLEN+2. That is 34 cycles for XLEN=32.
- Divide-by-zero and overflow: `done_o` in cycle 2.
- Reset asserted in mid-operation overrides everything on the next edge.
- Back-to-back: the earliest next `start_i` is the cycle after DONE.

## Configuration
- `MULDIV_FAST_MUL_EN`:
  - Defined: `MUL*` ops compute the 2·XLEN product with the combinational `*` operator in IDLE→FIX and skip CALC, so `done_o` comes in cycle 2. Divide is unchanged.
  - Undefined: all multiplies are iterative as described above, and no hardware multiplier is inferred.

## Structure
- `bitty_defs.v` gains:
  - the eight `EXE_MUL*`/`EXE_DIV*`/`EXE_REM*` aluop codes;
  - the state encodings `MD_IDLE`, `MD_CALC`, `MD_FIX`, `MD_DONE` (2 bits);
  - `StallReq`.
- One sub-module, `muldiv_sign_fix`: combinational conditional-negate and absolute value, parametrised by XLEN. It is instantiated for operand conditioning and for the result fix.
- `ctrl` ORs `stall_req_o` into its stall vector. `ex` muxes `result_o` onto `wdata_o` when `done_o` is high.

## Test plan
- `MUL`, 7 × −3 → `result_o` = 0xFFFFFFEB. `done_o` in cycle 34 (cycle 2 with `MULDIV_FAST_MUL_EN`).
- `MULHU`, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. `MULHSU`, −1 × 0xFFFFFFFF → 0xFFFFFFFF. `MULH`, −1 × −1 → 0x00000000.
- `DIV` −7/2 → 0xFFFFFFFD; `REM` −7/2 → 0xFFFFFFFF; `DIVU` 100/7 → 14; `REMU` 100/7 → 2.
- Divisor 0: `DIV` 5/0 → 0xFFFFFFFF and `REM` 5/0 → 5. Overflow: `DIV` 0x80000000/−1 → 0x80000000 and `REM` → 0. Both with `done_o` in cycle 2.
- `flush_i` at CALC cycle 10 → IDLE next cycle, no `done_o`, `stall_req_o` 0, previous `result_o` held. A `start_i` pulse during CALC is ignored.
- `rst` low at CALC cycle 5 → all outputs 0 next cycle. After `rst` is released, `DIVU` 9/3 → 3 with normal latency.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared definitions for the RV32M multiply/divide unit.
//   - alu_op_t / reg_addr_t : widths of the decoded aluop code and register address
//   - EXE_MUL* / EXE_DIV* / EXE_REM* : aluop codes handled by ex_muldiv
//   - md_state_e : MD_IDLE, MD_CALC, MD_FIX, MD_DONE (2-bit encoding)
//   - RST_ENABLE, STALL_REQ : reset level and stall-request level
//   - helper functions that classify an aluop code
package ex_muldiv_pkg;

    localparam int ALU_OP_W   = 8;
    localparam int REG_ADDR_W = 5;

    typedef logic [ALU_OP_W-1:0]   alu_op_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam alu_op_t EXE_MUL    = 8'h20;
    localparam alu_op_t EXE_MULH   = 8'h21;
    localparam alu_op_t EXE_MULHSU = 8'h22;
    localparam alu_op_t EXE_MULHU  = 8'h23;
    localparam alu_op_t EXE_DIV    = 8'h24;
    localparam alu_op_t EXE_DIVU   = 8'h25;
    localparam alu_op_t EXE_REM    = 8'h26;
    localparam alu_op_t EXE_REMU   = 8'h27;

    localparam logic RST_ENABLE = 1'b0;
    localparam logic STALL_REQ  = 1'b1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic is_md_op(input alu_op_t op);
        return op inside {EXE_MUL, EXE_MULH, EXE_MULHSU, EXE_MULHU,
                          EXE_DIV, EXE_DIVU, EXE_REM, EXE_REMU};
    endfunction

    function automatic logic is_mul_op(input alu_op_t op);
        return op inside {EXE_MUL, EXE_MULH, EXE_MULHSU, EXE_MULHU};
    endfunction

    // DIV and REM work on signed magnitudes; DIVU/REMU do not.
    function automatic logic is_signed_div(input alu_op_t op);
        return op inside {EXE_DIV, EXE_REM};
    endfunction

    function automatic logic is_rem_op(input alu_op_t op);
        return op inside {EXE_REM, EXE_REMU};
    endfunction

    // rs1 is treated as signed by MUL, MULH and MULHSU.
    function automatic logic mul_a_signed(input alu_op_t op);
        return op inside {EXE_MUL, EXE_MULH, EXE_MULHSU};
    endfunction

    // rs2 is treated as signed only by MUL and MULH.
    function automatic logic mul_b_signed(input alu_op_t op);
        return op inside {EXE_MUL, EXE_MULH};
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: request/response bundle between the EX stage and ex_muldiv.
//   start_i, aluop_i, reg1_i, reg2_i, wd_i, flush_i : request side (EX -> unit)
//   stall_req_o, done_o, result_o, wd_o             : response side (unit -> EX/ctrl)
//   modport slave  : the multiply/divide unit
//   modport master : the EX stage (or a testbench)
interface ex_muldiv_if
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
);

    logic            start_i;
    alu_op_t         aluop_i;
    logic [XLEN-1:0] reg1_i;
    logic [XLEN-1:0] reg2_i;
    reg_addr_t       wd_i;
    logic            flush_i;
    logic            stall_req_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    reg_addr_t       wd_o;

    modport slave (
        input  start_i, aluop_i, reg1_i, reg2_i, wd_i, flush_i,
        output stall_req_o, done_o, result_o, wd_o
    );

    modport master (
        output start_i, aluop_i, reg1_i, reg2_i, wd_i, flush_i,
        input  stall_req_o, done_o, result_o, wd_o
    );

endinterface

// File: rtl/ex_muldiv_sign_fix.sv
// ex_muldiv_sign_fix: combinational conditional two's-complement negate
// (the muldiv sign-fix block). With neg_i tied to the operand's sign bit it
// yields the absolute value; with neg_i driven by the result sign it applies
// the quotient/remainder sign correction. Negation is modulo 2^XLEN.
//   val_i [XLEN] : value to condition
//   neg_i        : 1 = negate, 0 = pass through
//   res_o [XLEN] : conditioned value
module ex_muldiv_sign_fix #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] val_i,
    input  logic            neg_i,
    output logic [XLEN-1:0] res_o
);

    assign res_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide execute unit, one result bit per
// cycle, with abort-on-flush.
//   clk : clock
//   rst : synchronous reset, active low
//   bus : ex_muldiv_if.slave (start/aluop/operands/wd/flush in;
//         stall_req/done/result/wd out)
// Optional feature: define MULDIV_FAST_MUL_EN to compute all MUL* ops with a
// combinational multiplier in IDLE->FIX (done in cycle 2). Undefined (default),
// multiplies run the XLEN-cycle shift-add loop and no multiplier is inferred.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave bus
);

    localparam int PW = 2 * XLEN;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    alu_op_t          op_q;
    reg_addr_t        wd_pend_q;   // destination captured at launch
    reg_addr_t        wd_q;        // destination presented with the result
    logic [PW-1:0]    op_a_q;      // multiplicand, shifted left each step
    logic [XLEN:0]    op_b_q;      // multiplier (arith shift right) or divisor
    logic [PW-1:0]    acc_q;       // product, or {remainder, quotient}
    logic             q_neg_q;
    logic             r_neg_q;
    logic [XLEN-1:0]  result_q;
    logic             done_q;

    // ------------------------------------------------------------------
    // Launch-side operand conditioning
    // ------------------------------------------------------------------
    logic            launch;
    logic            sdiv;
    logic            a_neg, b_neg;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [PW-1:0]   mul_a_ext;
    logic [XLEN:0]   mul_b_ext;

    ex_muldiv_sign_fix #(.XLEN(XLEN)) u_abs_a (
        .val_i (bus.reg1_i),
        .neg_i (a_neg),
        .res_o (a_abs)
    );

    ex_muldiv_sign_fix #(.XLEN(XLEN)) u_abs_b (
        .val_i (bus.reg2_i),
        .neg_i (b_neg),
        .res_o (b_abs)
    );

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        launch    = 1'b0;
        sdiv      = is_signed_div(bus.aluop_i);
        a_neg     = sdiv & bus.reg1_i[XLEN-1];
        b_neg     = sdiv & bus.reg2_i[XLEN-1];
        div_zero  = (bus.reg2_i == '0);
        div_ovf   = sdiv
                  && (bus.reg1_i == {1'b1, {(XLEN-1){1'b0}}})
                  && (bus.reg2_i == '1);
        mul_a_ext = {{XLEN{mul_a_signed(bus.aluop_i) & bus.reg1_i[XLEN-1]}}, bus.reg1_i};
        mul_b_ext = {mul_b_signed(bus.aluop_i) & bus.reg2_i[XLEN-1], bus.reg2_i};
        // A flush in IDLE wins over a simultaneous start.
        if (state_q == MD_IDLE && bus.start_i && is_md_op(bus.aluop_i) && !bus.flush_i) begin
            launch = 1'b1;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]   fast_a, fast_b;
    logic signed [PW+1:0]   fast_prod;

    always_comb begin
        fast_a    = mul_a_ext[XLEN:0];
        fast_b    = mul_b_ext;
        fast_prod = fast_a * fast_b;
    end
`endif

    // ------------------------------------------------------------------
    // One CALC step
    // ------------------------------------------------------------------
    logic            calc_last;
    logic [XLEN:0]   div_trial;
    logic [XLEN:0]   div_diff;
    logic [PW-1:0]   acc_calc;

    always_comb begin
        calc_last = (cnt_q == CNT_W'(XLEN - 1));
        // Partial remainder shifted left with the next dividend bit brought in.
        div_trial = {acc_q[PW-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_trial - {1'b0, op_b_q[XLEN-1:0]};
        acc_calc  = acc_q;
        if (is_mul_op(op_q)) begin
            if (op_b_q[0]) begin
                // The multiplier's top bit has negative weight when it is
                // signed, so the last partial product is subtracted.
                if (calc_last && op_b_q[XLEN]) begin
                    acc_calc = acc_q - op_a_q;
                end else begin
                    acc_calc = acc_q + op_a_q;
                end
            end
        end else if (!div_diff[XLEN]) begin
            acc_calc = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_calc = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // FIX: sign correction and word select
    // ------------------------------------------------------------------
    logic [XLEN-1:0] quot_fix, rem_fix, fix_result;

    ex_muldiv_sign_fix #(.XLEN(XLEN)) u_fix_q (
        .val_i (acc_q[XLEN-1:0]),
        .neg_i (q_neg_q),
        .res_o (quot_fix)
    );

    ex_muldiv_sign_fix #(.XLEN(XLEN)) u_fix_r (
        .val_i (acc_q[PW-1:XLEN]),
        .neg_i (r_neg_q),
        .res_o (rem_fix)
    );

    always_comb begin
        fix_result = '0;
        unique case (op_q)
            EXE_MUL:                         fix_result = acc_q[XLEN-1:0];
            EXE_MULH, EXE_MULHSU, EXE_MULHU: fix_result = acc_q[PW-1:XLEN];
            EXE_DIV, EXE_DIVU:               fix_result = quot_fix;
            EXE_REM, EXE_REMU:               fix_result = rem_fix;
            default:                         fix_result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            wd_pend_q <= '0;
            wd_q      <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            acc_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                MD_IDLE: begin
                    if (launch) begin
                        op_q      <= bus.aluop_i;
                        wd_pend_q <= bus.wd_i;
                        cnt_q     <= '0;
                        q_neg_q   <= 1'b0;
                        r_neg_q   <= 1'b0;
                        if (is_mul_op(bus.aluop_i)) begin
`ifdef MULDIV_FAST_MUL_EN
                            acc_q   <= fast_prod[PW-1:0];
                            state_q <= MD_FIX;
`else
                            op_a_q  <= mul_a_ext;
                            op_b_q  <= mul_b_ext;
                            acc_q   <= '0;
                            state_q <= MD_CALC;
`endif
                        end else if (div_zero) begin
                            // Preload so FIX yields quotient all-ones and
                            // remainder = dividend without sign correction.
                            acc_q   <= {bus.reg1_i, {XLEN{1'b1}}};
                            state_q <= MD_FIX;
                        end else if (div_ovf) begin
                            // Quotient = dividend, remainder = 0.
                            acc_q   <= {{XLEN{1'b0}}, bus.reg1_i};
                            state_q <= MD_FIX;
                        end else begin
                            acc_q   <= {{XLEN{1'b0}}, a_abs};
                            op_b_q  <= {1'b0, b_abs};
                            q_neg_q <= a_neg ^ b_neg;
                            r_neg_q <= a_neg;
                            state_q <= MD_CALC;
                        end
                    end
                end
                MD_CALC: begin
                    if (bus.flush_i) begin
                        state_q <= MD_IDLE;
                    end else begin
                        acc_q <= acc_calc;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (is_mul_op(op_q)) begin
                            op_a_q <= {op_a_q[PW-2:0], 1'b0};
                            op_b_q <= {op_b_q[XLEN], op_b_q[XLEN:1]};
                        end
                        if (calc_last) begin
                            state_q <= MD_FIX;
                        end
                    end
                end
                MD_FIX: begin
                    if (bus.flush_i) begin
                        state_q <= MD_IDLE;
                    end else begin
                        result_q <= fix_result;
                        wd_q     <= wd_pend_q;
                        done_q   <= 1'b1;
                        state_q  <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    state_q <= MD_IDLE;
                end
                default: begin
                    state_q <= MD_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Stall drops in DONE so the pipeline advances in the done_o cycle.
    always_comb begin
        bus.stall_req_o = ~STALL_REQ;
        if ((state_q == MD_IDLE && bus.start_i && is_md_op(bus.aluop_i))
            || state_q == MD_CALC || state_q == MD_FIX) begin
            bus.stall_req_o = STALL_REQ;
        end
    end

    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
    assign bus.wd_o     = wd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed self-checking bench for ex_muldiv (XLEN = 32).
// A table of {op, rs1, rs2, expected result, expected done cycle} records is
// applied back to back; hand-written sequences cover start-during-CALC,
// flush-during-CALC, flush+start in IDLE and reset-during-CALC.
// Cycle 0 is the cycle in which start_i is high.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;
    localparam int SPC_LAT = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ex_muldiv_if #(.XLEN(XLEN)) bus ();

    ex_muldiv #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    function automatic vec_t mk(input alu_op_t op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        return v;
    endfunction

    vec_t vecs [23];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input reg_addr_t wd);
        step();
        bus.aluop_i = op;
        bus.reg1_i  = a;
        bus.reg2_i  = b;
        bus.wd_i    = wd;
        bus.start_i = 1'b1;
    endtask

    // Waits up to budget cycles for done_o; lat = -1 if it never came.
    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            step();
            if (c == 1) bus.start_i = 1'b0;
            #1;
            if (bus.done_o) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_vec(input string name, input alu_op_t op, input logic [31:0] a,
                           input logic [31:0] b, input reg_addr_t wd,
                           input logic [31:0] exp, input int exp_lat);
        int lat;
        launch(op, a, b, wd);
        #1;
        check({name, "_stall_c0"}, 32'(bus.stall_req_o), 32'd1);
        wait_done(40, lat);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_result"}, bus.result_o, exp);
        check({name, "_wd"}, 32'(bus.wd_o), 32'(wd));
        check({name, "_stall_done"}, 32'(bus.stall_req_o), 32'd0);
        step();
        #1;
        check({name, "_done_pulse"}, 32'(bus.done_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int done_seen;

        bus.start_i = 1'b0;
        bus.aluop_i = '0;
        bus.reg1_i  = '0;
        bus.reg2_i  = '0;
        bus.wd_i    = '0;
        bus.flush_i = 1'b0;
        rst         = 1'b0;

        vecs[0]  = mk(EXE_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
        vecs[1]  = mk(EXE_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
        vecs[2]  = mk(EXE_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);
        vecs[3]  = mk(EXE_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT);
        vecs[4]  = mk(EXE_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
        vecs[5]  = mk(EXE_MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000, MUL_LAT);
        vecs[6]  = mk(EXE_MULHU,  32'h80000000, 32'd2,        32'h00000001, MUL_LAT);
        vecs[7]  = mk(EXE_MUL,    32'h12345678, 32'h10,       32'h23456780, MUL_LAT);
        vecs[8]  = mk(EXE_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT);
        vecs[9]  = mk(EXE_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT);
        vecs[10] = mk(EXE_DIVU,   32'd100,      32'd7,        32'd14,       DIV_LAT);
        vecs[11] = mk(EXE_REMU,   32'd100,      32'd7,        32'd2,        DIV_LAT);
        vecs[12] = mk(EXE_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT);
        vecs[13] = mk(EXE_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        DIV_LAT);
        vecs[14] = mk(EXE_REM,    32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, DIV_LAT);
        vecs[15] = mk(EXE_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, SPC_LAT);
        vecs[16] = mk(EXE_REM,    32'd5,        32'd0,        32'd5,        SPC_LAT);
        vecs[17] = mk(EXE_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, SPC_LAT);
        vecs[18] = mk(EXE_REMU,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, SPC_LAT);
        vecs[19] = mk(EXE_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPC_LAT);
        vecs[20] = mk(EXE_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        SPC_LAT);
        vecs[21] = mk(EXE_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        DIV_LAT);
        vecs[22] = mk(EXE_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, DIV_LAT);

        // Reset state
        repeat (3) step();
        check("rst_result", bus.result_o, 32'd0);
        check("rst_wd", 32'(bus.wd_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_stall", 32'(bus.stall_req_o), 32'd0);
        rst = 1'b1;

        // Table-driven vectors, back to back
        for (int i = 0; i < 23; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    reg_addr_t'(i + 1), vecs[i].exp, vecs[i].lat);
        end

        // start_i pulse during CALC (a div-by-zero that would finish fast) is ignored
        launch(EXE_DIVU, 32'd100, 32'd7, 5'd3);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (c == 1) bus.start_i = 1'b0;
            if (c == 5) begin
                bus.start_i = 1'b1;
                bus.aluop_i = EXE_DIV;
                bus.reg1_i  = 32'd5;
                bus.reg2_i  = 32'd0;
                bus.wd_i    = 5'd4;
            end
            if (c == 6) bus.start_i = 1'b0;
            #1;
            if (c == 20) check("ign_stall_calc", 32'(bus.stall_req_o), 32'd1);
            if (bus.done_o) begin
                lat = c;
                break;
            end
        end
        check("ign_latency", 32'(lat), 32'd34);
        check("ign_result", bus.result_o, 32'd14);
        check("ign_wd", 32'(bus.wd_o), 32'd3);
        step();

        // flush_i at CALC cycle 10: back to IDLE, no done, result held
        launch(EXE_DIV, 32'hFFFFFFF9, 32'd2, 5'd9);
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 1) bus.start_i = 1'b0;
        end
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        #1;
        check("flush_done", 32'(bus.done_o), 32'd0);
        check("flush_stall", 32'(bus.stall_req_o), 32'd0);
        check("flush_result_held", bus.result_o, 32'd14);
        check("flush_wd_held", 32'(bus.wd_o), 32'd3);
        done_seen = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (bus.done_o) done_seen++;
        end
        check("flush_no_done", 32'(done_seen), 32'd0);

        // flush_i together with start_i in IDLE: nothing launched
        launch(EXE_DIV, 32'd5, 32'd0, 5'd4);
        bus.flush_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        #1;
        check("flush_start_stall", 32'(bus.stall_req_o), 32'd0);
        done_seen = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.done_o) done_seen++;
        end
        check("flush_start_no_done", 32'(done_seen), 32'd0);
        check("flush_start_result", bus.result_o, 32'd14);

        // rst low at CALC cycle 5: all outputs zero next cycle
        launch(EXE_REM, 32'hFFFFFFF9, 32'd2, 5'd7);
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 1) bus.start_i = 1'b0;
        end
        rst = 1'b0;
        step();
        #1;
        check("midrst_result", bus.result_o, 32'd0);
        check("midrst_wd", 32'(bus.wd_o), 32'd0);
        check("midrst_done", 32'(bus.done_o), 32'd0);
        check("midrst_stall", 32'(bus.stall_req_o), 32'd0);
        rst = 1'b1;
        run_vec("post_rst_divu", EXE_DIVU, 32'd9, 32'd3, 5'd11, 32'd3, DIV_LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
